next_pc_logic: RTL and testbench



---
 rtl/next_pc_logic_if.sv | 56 +++++
 rtl/next_pc_logic.sv | 58 +++++
 tb/tb_next_pc_logic.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/next_pc_logic_if.sv
// next_pc_logic_if
//   Bundles the next-PC selection signals into one port.
//
//   Inputs to the selector:
//     CurrentPC     64  address of the instruction currently executing
//     SignExtImm64  64  sign-extended byte offset for branches
//     Branch         1  conditional (CBZ-type) branch
//     ALUZero        1  ALU result is zero
//     UCbranch       1  unconditional (B-type) branch
//   Outputs from the selector:
//     NextPC        64  combinational next-instruction address
//     Taken          1  combinational branch-taken flag
//     PCReg         64  registered NextPC (program counter)
//     TakenReg       1  registered Taken
//
//   Handshake: there is none. Every input is valid on every cycle and the
//   selector has no stall or enable, so no valid/ready pair exists here.
//
//   Modports:
//     master - the side that supplies PC/control and observes the results
//     slave  - the next-PC selector itself
interface next_pc_logic_if;
    logic [63:0] CurrentPC;
    logic [63:0] SignExtImm64;
    logic        Branch;
    logic        ALUZero;
    logic        UCbranch;
    logic [63:0] NextPC;
    logic        Taken;
    logic [63:0] PCReg;
    logic        TakenReg;

    modport master (
        output CurrentPC,
        output SignExtImm64,
        output Branch,
        output ALUZero,
        output UCbranch,
        input  NextPC,
        input  Taken,
        input  PCReg,
        input  TakenReg
    );

    modport slave (
        input  CurrentPC,
        input  SignExtImm64,
        input  Branch,
        input  ALUZero,
        input  UCbranch,
        output NextPC,
        output Taken,
        output PCReg,
        output TakenReg
    );
endinterface

// File: rtl/next_pc_logic.sv
// next_pc_logic
//   Next-program-counter selection for the single-cycle 64-bit datapath.
//   Chooses between the sequential address (PC + 4) and a branch target
//   (PC + sign-extended byte offset). NextPC/Taken are purely combinational;
//   PCReg/TakenReg are their registered copies for the PC register and trace.
//
//   Ports:
//     CLK    in   system clock, registered outputs update on rising edge
//     Reset  in   asynchronous, active-high; clears PCReg and TakenReg
//     bus    slave modport of next_pc_logic_if (see that file for signals)
module next_pc_logic (
    input  logic            CLK,
    input  logic            Reset,
    next_pc_logic_if.slave  bus
);

    logic [63:0] seq_pc;
    logic [63:0] target_pc;
    logic        taken;
    logic [63:0] next_pc;

    // Both adds are plain modulo-2^64 sums: negative offsets work through
    // two's-complement wrap and overflow wraps silently. The offset is
    // already in byte units, so it is added without any shift, and no
    // alignment is enforced on either operand.
    always_comb begin
        seq_pc    = bus.CurrentPC + 64'h4;
        target_pc = bus.CurrentPC + bus.SignExtImm64;
    end

    // An unconditional branch wins regardless of Branch/ALUZero; a
    // conditional branch is taken only when the ALU result is zero.
    always_comb begin
        taken   = bus.UCbranch | (bus.Branch & bus.ALUZero);
        next_pc = taken ? target_pc : seq_pc;
    end

    assign bus.NextPC = next_pc;
    assign bus.Taken  = taken;

    // Registered copies; reset clears them immediately, without a clock.
    logic [63:0] pc_q;
    logic        taken_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q    <= 64'h0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= next_pc;
            taken_q <= taken;
        end
    end

    assign bus.PCReg    = pc_q;
    assign bus.TakenReg = taken_q;

endmodule

// File: tb/tb_next_pc_logic.sv
module tb_next_pc_logic;

    // ---------------- clock / reset ----------------
    logic CLK;
    logic Reset;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    next_pc_logic_if bus ();

    next_pc_logic dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int compared_cnt;
    int mismatch_cnt;
    logic [64:0] exp_q[$];   // {taken, next_pc} expected at the next edge

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: branch rule evaluated directly, then a wrap-around add.
    function automatic logic [64:0] model(input logic [63:0] pc, input logic [63:0] imm,
                                          input logic b, input logic z, input logic u);
        logic        tk;
        logic [63:0] off;
        tk  = (u == 1'b1) || ((b == 1'b1) && (z == 1'b1));
        off = tk ? imm : 64'd4;
        return {tk, 64'(pc + off)};
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic [63:0] pc, input logic [63:0] imm,
                         input logic b, input logic z, input logic u);
        bus.CurrentPC    = pc;
        bus.SignExtImm64 = imm;
        bus.Branch       = b;
        bus.ALUZero      = z;
        bus.UCbranch     = u;
    endtask

    // Drive on the falling edge, check combinational outputs 1 ns later,
    // then check the registered outputs 1 ns after the rising edge.
    task automatic cycle(input string tag, input logic [63:0] pc, input logic [63:0] imm,
                         input logic b, input logic z, input logic u);
        logic [64:0] e;
        logic [64:0] r;
        @(negedge CLK);
        apply(pc, imm, b, z, u);
        e = model(pc, imm, b, z, u);
        exp_q.push_back(e);
        #1;
        check({tag, ".next_pc"}, bus.NextPC, e[63:0]);
        check({tag, ".taken"}, 64'(bus.Taken), 64'(e[64]));
        @(posedge CLK);
        #1;
        r = exp_q.pop_front();
        check({tag, ".pc_reg"}, bus.PCReg, r[63:0]);
        check({tag, ".taken_reg"}, 64'(bus.TakenReg), 64'(r[64]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] rpc;
        logic [63:0] rimm;
        logic [64:0] e;
        compared_cnt = 0;
        mismatch_cnt = 0;
        Reset = 1'b0;
        apply(64'h0, 64'h0, 1'b0, 1'b0, 1'b0);

        // Load a nonzero value, then assert reset between edges.
        cycle("preload", 64'h1000, 64'h40, 1'b0, 1'b0, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst.pc_reg", bus.PCReg, 64'h0);
        check("async_rst.taken_reg", 64'(bus.TakenReg), 64'h0);
        @(posedge CLK);
        #1;
        check("rst_hold.pc_reg", bus.PCReg, 64'h0);
        check("rst_hold.taken_reg", 64'(bus.TakenReg), 64'h0);

        // Release with a taken conditional branch pending.
        @(negedge CLK);
        apply(64'h10, 64'h10, 1'b1, 1'b1, 1'b0);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("release.pc_reg", bus.PCReg, 64'h20);
        check("release.taken_reg", 64'(bus.TakenReg), 64'h1);

        // Directed vectors with hand-computed expectations.
        cycle("seq",       64'h0,  64'h10, 1'b0, 1'b0, 1'b0);
        check("seq.const", bus.NextPC, 64'h4);
        cycle("cb_ntaken", 64'h10, 64'h10, 1'b1, 1'b0, 1'b0);
        check("cb_ntaken.const", bus.NextPC, 64'h14);
        cycle("cb_taken",  64'h10, 64'h10, 1'b1, 1'b1, 1'b0);
        check("cb_taken.const", bus.NextPC, 64'h20);
        cycle("ub",        64'h10, 64'h10, 1'b0, 1'b0, 1'b1);
        check("ub.const", bus.NextPC, 64'h20);
        cycle("ub_b",      64'h10, 64'h10, 1'b1, 1'b0, 1'b1);
        check("ub_b.const", bus.NextPC, 64'h20);
        cycle("zero_only", 64'h10, 64'h10, 1'b0, 1'b1, 1'b0);
        check("zero_only.const", bus.NextPC, 64'h14);
        cycle("neg_off",   64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b1);
        check("neg_off.const", bus.NextPC, 64'hF0);
        cycle("wrap_seq",  64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b0, 1'b0);
        check("wrap_seq.const", bus.NextPC, 64'h0);
        cycle("wrap_br",   64'hFFFF_FFFF_FFFF_FFF0, 64'h23, 1'b1, 1'b1, 1'b0);
        check("wrap_br.const", bus.NextPC, 64'h13);
        cycle("unaligned", 64'h3, 64'h5, 1'b0, 1'b0, 1'b1);
        check("unaligned.const", bus.NextPC, 64'h8);

        // Mid-cycle reset: registers clear before the next edge while the
        // combinational path keeps following the inputs.
        @(negedge CLK);
        apply(64'h2000, 64'h8, 1'b0, 1'b0, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst.pc_reg", bus.PCReg, 64'h0);
        check("mid_rst.taken_reg", 64'(bus.TakenReg), 64'h0);
        check("mid_rst.next_pc", bus.NextPC, 64'h2008);
        check("mid_rst.taken", 64'(bus.Taken), 64'h1);
        @(negedge CLK);
        Reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
                1:       rpc = 64'($urandom_range(0, 255));
                default: rpc = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 2))
                0:       rimm = -64'($urandom_range(0, 4096));
                1:       rimm = 64'($urandom_range(0, 4096));
                default: rimm = {$urandom, $urandom};
            endcase
            cycle("rand", rpc, rimm, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Independent spot check of the model against a literal value.
        e = model(64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
        apply(64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
        #1;
        check("final.next_pc", bus.NextPC, e[63:0]);
        check("final.next_pc_const", bus.NextPC, 64'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
